// File: rtl/ex_mem_pipe.sv
// Execute-to-memory stage: captures ALU result, flags and control; resolves branches and jumps.
// Latency: one cycle from accept to o_valid / o_redirect; holds up to two entries in a skid buffer.
// Backpressure: o_ready is registered and drops only when both entries are occupied (optional misalign check: EX_MEM_MISALIGN_CHK_EN).
module ex_mem_pipe #(
  parameter int              XLEN          = 32,
  parameter logic [XLEN-1:0] RESET_PC_LINK = '0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_alu_result,
  input  logic            i_zero,
  input  logic            i_neg,
  input  logic            i_negU,
  input  logic [2:0]      i_funct3,
  input  logic            i_is_branch,
  input  logic            i_is_jal,
  input  logic            i_is_jalr,
  input  logic [4:0]      i_rd,
  input  logic            i_reg_we,
  input  logic            i_mem_we,
  input  logic            i_mem_re,
  input  logic [XLEN-1:0] i_store_data,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic [XLEN-1:0] o_pc4,
  output logic [4:0]      o_rd,
  output logic            o_reg_we,
  output logic            o_mem_we,
  output logic            o_mem_re,
  output logic [XLEN-1:0] o_store_data,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_misalign
);

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd;
    logic            reg_we;
    logic            mem_we;
    logic            mem_re;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic            ready_q;
  entry_t          out_q, skid_q, new_entry;
  logic            redirect_q, misalign_q;
  logic [XLEN-1:0] redirect_pc_q;

  logic            accept, pop;
  logic            cond, taken, fault;
  logic [XLEN-1:0] pc4_in, branch_target, target;
  logic            load_out, load_skid, out_from_skid;

  assign accept = i_valid & ready_q & ~i_flush;
  assign pop    = o_valid & i_ready;

  assign pc4_in        = i_pc + XLEN'(4);
  assign branch_target = i_pc + i_imm;

  // Branch condition from funct3; 010/011 never taken.
  always_comb begin
    cond = 1'b0;
    case (i_funct3)
      3'b000:  cond = i_zero;
      3'b001:  cond = ~i_zero;
      3'b100:  cond = i_neg;
      3'b101:  cond = ~i_neg;
      3'b110:  cond = i_negU;
      3'b111:  cond = ~i_negU;
      default: cond = 1'b0;
    endcase
  end

  // Resolve taken and target with priority jalr > jal > branch.
  always_comb begin
    taken  = 1'b0;
    target = branch_target;
    if (i_is_jalr) begin
      taken  = 1'b1;
      target = i_alu_result & ~XLEN'(1);
    end else if (i_is_jal) begin
      taken  = 1'b1;
      target = branch_target;
    end else if (i_is_branch) begin
      taken  = cond;
      target = branch_target;
    end
  end

`ifdef EX_MEM_MISALIGN_CHK_EN
  assign fault = taken & (target[1:0] != 2'b00);
`else
  assign fault = 1'b0;
`endif

  // Build the entry to enqueue; a faulting jump must not write its link register.
  always_comb begin
    new_entry            = '0;
    new_entry.result     = (i_is_jal | i_is_jalr) ? pc4_in : i_alu_result;
    new_entry.pc4        = pc4_in;
    new_entry.store_data = i_store_data;
    new_entry.rd         = i_rd;
    new_entry.reg_we     = i_reg_we & ~fault;
    new_entry.mem_we     = i_mem_we;
    new_entry.mem_re     = i_mem_re;
  end

  // Skid buffer next-state and datapath steering.
  always_comb begin
    state_n       = state;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_n  = ONE;
          load_out = 1'b1;
        end
      end
      ONE: begin
        if (accept && pop) begin
          load_out = 1'b1;
        end else if (accept) begin
          state_n   = FULL;
          load_skid = 1'b1;
        end else if (pop) begin
          state_n = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_n       = ONE;
          out_from_skid = 1'b1;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  // State register; ready is registered from the next state so no comb path from i_ready.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state   <= state_n;
      ready_q <= (state_n != FULL);
    end
  end

  // Output entry register: loads a new beat or the older skid entry.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      out_q     <= '0;
      out_q.pc4 <= RESET_PC_LINK;
    end else if (load_out) begin
      out_q <= new_entry;
    end else if (out_from_skid) begin
      out_q <= skid_q;
    end
  end

  // Skid entry register: parks a beat accepted while the output is stalled.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      skid_q <= '0;
    end else if (load_skid) begin
      skid_q <= new_entry;
    end
  end

  // One-cycle redirect / misalign pulses; target holds between pulses.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      redirect_q    <= 1'b0;
      misalign_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      redirect_q <= accept & taken & ~fault;
      misalign_q <= accept & fault;
      if (accept && taken) begin
        redirect_pc_q <= target;
      end
    end
  end

  assign o_ready       = ready_q;
  assign o_valid       = (state != EMPTY);
  assign o_result      = out_q.result;
  assign o_pc4         = out_q.pc4;
  assign o_rd          = out_q.rd;
  assign o_reg_we      = out_q.reg_we;
  assign o_mem_we      = out_q.mem_we;
  assign o_mem_re      = out_q.mem_re;
  assign o_store_data  = out_q.store_data;
  assign o_redirect    = redirect_q;
  assign o_redirect_pc = redirect_pc_q;
  assign o_misalign    = misalign_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: queue-based reference model plus directed vectors.
// Model updates on posedge, outputs compared on negedge every cycle.
// Literal expectations pin the model on the key scenarios.
module tb_ex_mem_pipe;

  localparam logic [31:0] LINK = 32'h0000_0DEC;

  logic        clk, rst_n;
  logic        v, fl, zr, ng, ngu, br, jl, jr, rwe, mwe, mre, rdy;
  logic [31:0] pc, imm, alu, sd;
  logic [2:0]  f3;
  logic [4:0]  rd;

  logic        o_ready, o_valid, o_reg_we, o_mem_we, o_mem_re, o_redirect, o_misalign;
  logic [31:0] o_result, o_pc4, o_store_data, o_redirect_pc;
  logic [4:0]  o_rd;

  ex_mem_pipe #(.XLEN(32), .RESET_PC_LINK(LINK)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v), .o_ready(o_ready), .i_flush(fl),
    .i_pc(pc), .i_imm(imm), .i_alu_result(alu), .i_zero(zr), .i_neg(ng), .i_negU(ngu),
    .i_funct3(f3), .i_is_branch(br), .i_is_jal(jl), .i_is_jalr(jr), .i_rd(rd),
    .i_reg_we(rwe), .i_mem_we(mwe), .i_mem_re(mre), .i_store_data(sd),
    .o_valid(o_valid), .i_ready(rdy), .o_result(o_result), .o_pc4(o_pc4), .o_rd(o_rd),
    .o_reg_we(o_reg_we), .o_mem_we(o_mem_we), .o_mem_re(o_mem_re), .o_store_data(o_store_data),
    .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc), .o_misalign(o_misalign)
  );

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] pc4;
    logic [31:0] sdata;
    logic [7:0]  ctrl;
  } exp_t;

  exp_t        q[$];
  logic        exp_redir, exp_mis, chk_en;
  logic [31:0] exp_rpc;
  int          checks, errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a two-deep FIFO of expected entries plus the redirect outcome.
  always @(posedge clk) begin
    logic        acc, tk, cnd, bad;
    logic [31:0] tgt;
    exp_t        e;
    if (!rst_n) begin
      q.delete();
      exp_redir = 1'b0;
      exp_mis   = 1'b0;
      exp_rpc   = 32'h0;
    end else begin
      acc = v && (q.size() < 2) && !fl;
      case (f3)
        3'd0: cnd = zr;    3'd1: cnd = !zr;
        3'd4: cnd = ng;    3'd5: cnd = !ng;
        3'd6: cnd = ngu;   3'd7: cnd = !ngu;
        default: cnd = 1'b0;
      endcase
      tk  = jr || jl || (br && cnd);
      tgt = jr ? {alu[31:1], 1'b0} : pc + imm;
      bad = 1'b0;
`ifdef EX_MEM_MISALIGN_CHK_EN
      bad = tk && (tgt % 4 != 0);
`endif
      if (q.size() > 0 && rdy) void'(q.pop_front());
      exp_redir = acc && tk && !bad;
      exp_mis   = acc && bad;
      if (acc && tk) exp_rpc = tgt;
      if (acc) begin
        e.result = (jl || jr) ? pc + 32'd4 : alu;
        e.pc4    = pc + 32'd4;
        e.sdata  = sd;
        e.ctrl   = {rd, rwe && !bad, mwe, mre};
        q.push_back(e);
      end
    end
  end

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", {31'b0, o_valid}, {31'b0, q.size() > 0});
      chk("ready", {31'b0, o_ready}, {31'b0, q.size() < 2});
      chk("redirect", {31'b0, o_redirect}, {31'b0, exp_redir});
      chk("misalign", {31'b0, o_misalign}, {31'b0, exp_mis});
      if (exp_redir || exp_mis) chk("redirect_pc", o_redirect_pc, exp_rpc);
      if (q.size() > 0) begin
        chk("result", o_result, q[0].result);
        chk("pc4", o_pc4, q[0].pc4);
        chk("store_data", o_store_data, q[0].sdata);
        chk("ctrl", {24'b0, o_rd, o_reg_we, o_mem_we, o_mem_re}, {24'b0, q[0].ctrl});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    v = 0; fl = 0; br = 0; jl = 0; jr = 0; zr = 0; ng = 0; ngu = 0; f3 = 0;
    pc = 0; imm = 0; alu = 0; sd = 0; rd = 0; rwe = 0; mwe = 0; mre = 0;
  endtask

  task automatic drive(input logic [31:0] p, input logic [31:0] im, input logic [31:0] a,
                       input logic [2:0] f, input logic b, input logic j, input logic jrr,
                       input logic z, input logic n, input logic nu,
                       input logic [4:0] d, input logic we);
    v = 1; fl = 0; pc = p; imm = im; alu = a; f3 = f; br = b; jl = j; jr = jrr;
    zr = z; ng = n; ngu = nu; rd = d; rwe = we; mwe = 0; mre = 0; sd = a ^ 32'hF0F0_0F0F;
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; errors = 0; chk_en = 0;
    rst_n = 0; rdy = 1; idle();
    step();
    chk_en = 1;
    step(); step();
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_ready", {31'b0, o_ready}, 32'd1);
    chk("rst_redirect", {31'b0, o_redirect}, 32'd0);
    chk("rst_pc4", o_pc4, LINK);
    chk("rst_result", o_result, 32'd0);
    chk("rst_rpc", o_redirect_pc, 32'd0);
    rst_n = 1;
    step();

    // BEQ taken
    drive(32'h100, 32'h20, 32'h0, 3'b000, 1, 0, 0, 1, 0, 0, 5'd0, 0);
    step(); idle();
    chk("beq_redirect", {31'b0, o_redirect}, 32'd1);
    chk("beq_target", o_redirect_pc, 32'h120);
    chk("beq_valid", {31'b0, o_valid}, 32'd1);
    step();
    chk("beq_pulse_end", {31'b0, o_redirect}, 32'd0);

    // BLTU not taken
    drive(32'h200, 32'h40, 32'h55, 3'b110, 1, 0, 0, 0, 0, 0, 5'd0, 0);
    step(); idle();
    chk("bltu_redirect", {31'b0, o_redirect}, 32'd0);
    chk("bltu_result", o_result, 32'h55);

    // JALR
    drive(32'h400, 32'h0, 32'h2003, 3'b000, 0, 0, 1, 0, 0, 0, 5'd5, 1);
    step(); idle();
    chk("jalr_target", o_redirect_pc, 32'h2002);
    chk("jalr_result", o_result, 32'h404);
    chk("jalr_we", {31'b0, o_reg_we}, 32'd1);
    step();

    // Backpressure: three beats against a stalled memory stage
    rdy = 0;
    drive(32'h500, 0, 32'h11, 3'b010, 0, 0, 0, 0, 0, 0, 5'd1, 1);
    step();
    drive(32'h504, 0, 32'h22, 3'b010, 0, 0, 0, 0, 0, 0, 5'd2, 1);
    step();
    chk("bp_ready_drop", {31'b0, o_ready}, 32'd0);
    drive(32'h508, 0, 32'h33, 3'b010, 0, 0, 0, 0, 0, 0, 5'd3, 1);
    step();
    chk("bp_hold", o_result, 32'h11);
    rdy = 1;
    step();
    chk("bp_second", o_result, 32'h22);
    step(); idle();
    chk("bp_third", o_result, 32'h33);
    step();

    // Flushed BNE taken: dropped entirely
    drive(32'h600, 32'h8, 0, 3'b001, 1, 0, 0, 0, 0, 0, 5'd0, 0);
    fl = 1;
    step(); idle();
    chk("flush_redirect", {31'b0, o_redirect}, 32'd0);
    chk("flush_valid", {31'b0, o_valid}, 32'd0);

    // JAL wrap-around
    drive(32'hFFFF_FFFC, 32'h4, 0, 3'b000, 0, 1, 0, 0, 0, 0, 5'd1, 1);
    step(); idle();
    chk("wrap_target", o_redirect_pc, 32'h0);
    chk("wrap_result", o_result, 32'h0);
    step();

    // JAL to a misaligned target
    drive(32'h100, 32'h2, 0, 3'b000, 0, 1, 0, 0, 0, 0, 5'd1, 1);
    step(); idle();
`ifdef EX_MEM_MISALIGN_CHK_EN
    chk("mis_flag", {31'b0, o_misalign}, 32'd1);
    chk("mis_redirect", {31'b0, o_redirect}, 32'd0);
    chk("mis_we", {31'b0, o_reg_we}, 32'd0);
`else
    chk("mis_redirect", {31'b0, o_redirect}, 32'd1);
    chk("mis_target", o_redirect_pc, 32'h102);
`endif
    step();

    // Mixed conditions, multi-flag priority and toggling ready
    for (int i = 0; i < 12; i++) begin
      rdy = (i % 3) != 2;
      drive(32'h1000 + i * 16, 32'h40 + i * 4, 32'h3000 + i * 7, 3'(i), i[0], i % 5 == 0,
            i % 7 == 3, i[1], i[2], i[3], 5'(i), i[0]);
      step();
    end
    idle(); rdy = 1;
    repeat (3) step();

    // Reset while FULL with a redirect pulse in flight
    rdy = 0;
    drive(32'h700, 0, 32'hA, 3'b010, 0, 0, 0, 0, 0, 0, 5'd4, 1);
    step();
    drive(32'h300, 32'h10, 0, 3'b000, 0, 1, 0, 0, 0, 0, 5'd1, 1);
    step(); idle();
    chk("full_ready", {31'b0, o_ready}, 32'd0);
    chk("full_redirect", {31'b0, o_redirect}, 32'd1);
    rst_n = 0;
    step();
    chk("rstfull_valid", {31'b0, o_valid}, 32'd0);
    chk("rstfull_redirect", {31'b0, o_redirect}, 32'd0);
    chk("rstfull_ready", {31'b0, o_ready}, 32'd1);
    rst_n = 1; rdy = 1;
    step(); step();

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
Execute-to-memory pipeline stage that sits directly downstream of the ALU. It captures the ALU result and compare flags (zero, neg, negU) together with the instruction's side-band control. It resolves conditional branches and jumps, emitting a one-cycle redirect. It buffers up to two entries in a skid buffer behind a valid/ready handshake, so memory-stage stalls do not create combinational ready paths back into execute.

Parameters:
XLEN, 32, datapath width of result, PC, immediate and store data
RESET_PC_LINK, 0, reset value of o_pc4 (debug visibility only)

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  synchronous active-low reset
i_valid  input  1  upstream beat valid
o_ready  output  1  stage can accept a beat; registered
i_flush  input  1  kill the incoming beat (hazard unit)
i_pc  input  XLEN  PC of the incoming instruction
i_imm  input  XLEN  sign-extended immediate
i_alu_result  input  XLEN  ALU o_1
i_zero  input  1  ALU o_zero
i_neg  input  1  ALU o_neg
i_negU  input  1  ALU o_negU
i_funct3  input  3  branch condition select
i_is_branch  input  1  conditional branch
i_is_jal  input  1  JAL
i_is_jalr  input  1  JALR
i_rd  input  5  destination register
i_reg_we  input  1  register write enable
i_mem_we  input  1  store
i_mem_re  input  1  load
i_store_data  input  XLEN  rs2 value for stores
o_valid  output  1  downstream beat valid
i_ready  input  1  memory stage accepts
o_result  output  XLEN  ALU result, or PC+4 for JAL/JALR
o_pc4  output  XLEN  i_pc+4 of the held entry
o_rd, o_reg_we, o_mem_we, o_mem_re, o_store_data  output  5/1/1/1/XLEN  held control and data
o_redirect  output  1  one-cycle pulse: fetch must jump
o_redirect_pc  output  XLEN  redirect target, valid when o_redirect=1
o_misalign  output  1  misaligned-target pulse (see Optional Feature)

Behaviour:
- Accept condition: accept = i_valid & o_ready & ~i_flush. A flushed beat is dropped entirely and produces no redirect. Already-buffered entries are older and are never flushed.
- Branch condition, by i_funct3:
  - 000 taken=zero
  - 001 taken=~zero
  - 100 taken=neg
  - 101 taken=~neg
  - 110 taken=negU
  - 111 taken=~negU
  - 010 and 011 are never taken.
- Jumps: JAL is always taken with target i_pc+i_imm. JALR is always taken with target i_alu_result & ~1.
- Branch target: i_pc+i_imm. All additions are mod 2^XLEN; wrap at 0xFFFFFFFC+4 gives 0.
- Redirect output: o_redirect and o_redirect_pc are registered and assert in the cycle after accept, for exactly one cycle. A redirect is issued on accept even if the entry is not yet forwarded downstream.
- Stored result: o_result is PC+4 for JAL/JALR, else i_alu_result. The branch's own entry is forwarded with reg_we and mem_we as supplied; the decoder drives them 0 for branches.
- Skid buffer FSM, states EMPTY, ONE, FULL:
  - EMPTY: on accept → ONE.
  - ONE: accept & ~(o_valid&i_ready) → FULL; ~accept & (o_valid&i_ready) → EMPTY; accept & pop → stays ONE, new entry replaces the output.
  - FULL: on pop → ONE, skid entry moves to the output register. No accept is possible in FULL.
- Handshake outputs: o_ready = (state != FULL), registered. o_valid = (state != EMPTY).
- Output stability: while o_valid=1 & i_ready=0, all o_* entry fields hold stable. Order is strictly FIFO.
- Reset (i_rst_n=0 at a clock edge): state → EMPTY; o_valid=0, o_ready=1, o_redirect=0, o_misalign=0, o_redirect_pc=0, o_result=0, o_rd=0, all enables 0, o_pc4=RESET_PC_LINK.
  - Reset mid-operation discards both entries and any pending redirect pulse.
  - o_ready is 1 in the first cycle after reset is released.
- Multiple flags: if more than one of i_is_branch, i_is_jal, i_is_jalr is set, priority is jalr > jal > branch.

Optional Feature:
EX_MEM_MISALIGN_CHK_EN
- Defined: on a taken redirect whose target[1:0] != 00, o_redirect stays 0. o_misalign pulses for one cycle, with o_redirect_pc = the faulting target. The entry is still enqueued with reg_we forced to 0.
- Undefined: o_misalign is tied 0 and targets are never checked.

Test Plan:
- BEQ, i_pc=0x100, i_imm=0x20, i_zero=1, ready high → next cycle o_redirect=1, o_redirect_pc=0x120, one cycle only; o_valid=1.
- BLTU, i_negU=0, i_funct3=110 → o_redirect stays 0; entry passes with o_result = i_alu_result.
- JALR, i_alu_result=0x2003, i_pc=0x400 → o_redirect_pc=0x2002, o_result=0x404, o_reg_we=1.
- i_ready=0 for 3 cycles with 3 beats offered → o_ready drops after beat 2. Releasing i_ready yields beats 1 then 2 in order, then accepts beat 3.
- i_flush=1 with a taken BNE → no redirect and no enqueue; state unchanged.
- Reset asserted in state FULL with a redirect pending → next cycle o_valid=0, o_redirect=0, o_ready=1. With EX_MEM_MISALIGN_CHK_EN, JAL to 0x102 → o_misalign=1, o_redirect=0.
